// File: rtl/elastic_pipeline_v1_0.sv
// -----------------------------------------------------------------------------
// elastic_pipeline_v1_0
//
// A chain of C_PIPE_STAGES registers with a valid/ready handshake on both
// ends. An empty stage always takes the word from the stage behind it, so
// gaps (bubbles) close up even while the output is stalled. A full pipe with
// the output ready accepts and emits in the same cycle, which sustains one
// word per clock.
//
// Parameters
//   C_WIDTH        data width in bits (1..64)
//   C_PIPE_STAGES  number of register stages (1..8)
//
// Ports
//   CLK        rising-edge clock
//   SCLR_N     synchronous active-low reset: clears valids, data and count
//   CE         clock enable; low freezes all state and blocks both handshakes
//   FLUSH      discards every held word on the next edge (only while CE=1)
//   D          upstream data
//   D_VALID    upstream word present
//   D_READY    pipeline accepts D this cycle
//   Q          downstream data (last stage register)
//   Q_VALID    downstream word present
//   Q_READY    downstream accepts Q this cycle
//   OCCUPANCY  registered number of valid stages
// -----------------------------------------------------------------------------
module elastic_pipeline_v1_0 #(
    parameter int C_WIDTH       = 16,
    parameter int C_PIPE_STAGES = 3
) (
    input  logic               CLK,
    input  logic               SCLR_N,
    input  logic               CE,
    input  logic               FLUSH,
    input  logic [C_WIDTH-1:0] D,
    input  logic               D_VALID,
    output logic               D_READY,
    output logic [C_WIDTH-1:0] Q,
    output logic               Q_VALID,
    input  logic               Q_READY,
    output logic [3:0]         OCCUPANCY
);

    localparam int LAST = C_PIPE_STAGES - 1;

    logic [C_WIDTH-1:0]       stage_data [C_PIPE_STAGES];
    logic [C_PIPE_STAGES-1:0] stage_valid;
    logic [3:0]               occupancy_q;

    logic                     run;
    logic                     kill;
    logic [C_PIPE_STAGES-1:0] advance;
    logic [C_PIPE_STAGES-1:0] in_valid;
    logic [C_WIDTH-1:0]       in_data [C_PIPE_STAGES];
    logic [C_PIPE_STAGES-1:0] next_valid;
    logic [3:0]               next_count;

    // Stages may only move when enabled, not flushing and out of reset.
    // Holding reset here keeps both handshakes low while SCLR_N is asserted.
    assign run  = SCLR_N && CE && !FLUSH;
    assign kill = CE && FLUSH;

    // Advance chain, walked from the output back towards the input. A stage
    // moves when it is empty or when the stage in front of it moves; the
    // stage in front of the last one is the downstream consumer.
    always_comb begin
        logic downstream;
        advance    = '0;
        downstream = Q_READY;
        for (int i = LAST; i >= 0; i--) begin
            advance[i] = run && (!stage_valid[i] || downstream);
            downstream = advance[i];
        end
    end

    // What each stage would load if it advanced: the upstream port for
    // stage 0, the previous stage for everything else.
    always_comb begin
        in_valid[0] = D_VALID;
        in_data[0]  = D;
        for (int i = 1; i < C_PIPE_STAGES; i++) begin
            in_valid[i] = stage_valid[i-1];
            in_data[i]  = stage_data[i-1];
        end
    end

    // Valid bits after the coming edge, and how many of them are set. The
    // count is registered so OCCUPANCY always matches the valids it sits
    // beside rather than being a combinational popcount.
    always_comb begin
        next_valid = stage_valid;
        for (int i = 0; i < C_PIPE_STAGES; i++) begin
            if (advance[i]) begin
                next_valid[i] = in_valid[i];
            end
        end
        if (kill) begin
            next_valid = '0;
        end
        next_count = '0;
        for (int i = 0; i < C_PIPE_STAGES; i++) begin
            next_count = next_count + {3'b000, next_valid[i]};
        end
    end

    // State registers. Data only loads when a real word arrives, so an
    // advancing bubble leaves the old contents in place; that keeps Q steady
    // after the last word has drained or been flushed.
    always_ff @(posedge CLK) begin
        if (!SCLR_N) begin
            stage_valid <= '0;
            occupancy_q <= '0;
            for (int i = 0; i < C_PIPE_STAGES; i++) begin
                stage_data[i] <= '0;
            end
        end else begin
            stage_valid <= next_valid;
            occupancy_q <= next_count;
            for (int i = 0; i < C_PIPE_STAGES; i++) begin
                if (advance[i] && in_valid[i]) begin
                    stage_data[i] <= in_data[i];
                end
            end
        end
    end

    assign D_READY   = advance[0];
    assign Q_VALID   = stage_valid[LAST] && run;
    assign Q         = stage_data[LAST];
    assign OCCUPANCY = occupancy_q;

endmodule

// File: tb/tb_elastic_pipeline_v1_0.sv
// -----------------------------------------------------------------------------
// tb_elastic_pipeline_v1_0
//
// Directed bench for elastic_pipeline_v1_0 with an 8-bit word and three
// stages. Inputs change 1 time unit after each rising edge and outputs are
// sampled 1 time unit later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_elastic_pipeline_v1_0;

    logic       CLK;
    logic       SCLR_N;
    logic       CE;
    logic       FLUSH;
    logic [7:0] D;
    logic       D_VALID;
    logic       D_READY;
    logic [7:0] Q;
    logic       Q_VALID;
    logic       Q_READY;
    logic [3:0] OCCUPANCY;

    int n_compared;
    int n_mismatched;

    elastic_pipeline_v1_0 #(
        .C_WIDTH       (8),
        .C_PIPE_STAGES (3)
    ) dut (
        .CLK       (CLK),
        .SCLR_N    (SCLR_N),
        .CE        (CE),
        .FLUSH     (FLUSH),
        .D         (D),
        .D_VALID   (D_VALID),
        .D_READY   (D_READY),
        .Q         (Q),
        .Q_VALID   (Q_VALID),
        .Q_READY   (Q_READY),
        .OCCUPANCY (OCCUPANCY)
    );

    // Free-running 100 MHz-style clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Reset held over two edges clears everything; after release an empty
    // pipe is ready for input and shows no output.
    task automatic test_reset();
        SCLR_N  = 1'b0;
        CE      = 1'b1;
        FLUSH   = 1'b0;
        D       = 8'hFF;
        D_VALID = 1'b1;
        Q_READY = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        n_compared++;
        if (Q !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL reset_q: got %h expected %h", Q, 8'h00);
        end
        n_compared++;
        if (Q_VALID !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_qvalid: got %b expected %b", Q_VALID, 1'b0);
        end
        n_compared++;
        if (D_READY !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_dready: got %b expected %b", D_READY, 1'b0);
        end
        n_compared++;
        if (OCCUPANCY !== 4'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_occ: got %0d expected %0d", OCCUPANCY, 0);
        end
        next_cycle();
        SCLR_N  = 1'b1;
        D_VALID = 1'b0;
        Q_READY = 1'b0;
        #1;
        n_compared++;
        if (D_READY !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL release_dready: got %b expected %b", D_READY, 1'b1);
        end
        n_compared++;
        if (Q_VALID !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL release_qvalid: got %b expected %b", Q_VALID, 1'b0);
        end
        next_cycle();
    endtask

    // 0x01..0x10 on consecutive cycles with the output always ready. Word k
    // is accepted in cycle k-1 and shows at Q in cycle k+2.
    task automatic test_streaming();
        logic       exp_qv;
        logic [7:0] exp_q;
        Q_READY = 1'b1;
        for (int k = 0; k < 20; k++) begin
            D_VALID = (k < 16);
            D       = 8'(k + 1);
            #1;
            exp_qv = (k >= 3) && (k <= 18);
            exp_q  = 8'(k - 2);
            n_compared++;
            if (Q_VALID !== exp_qv) begin
                n_mismatched++;
                $display("[TB] FAIL stream_qvalid cycle %0d: got %b expected %b", k, Q_VALID, exp_qv);
            end
            if (exp_qv) begin
                n_compared++;
                if (Q !== exp_q) begin
                    n_mismatched++;
                    $display("[TB] FAIL stream_q cycle %0d: got %h expected %h", k, Q, exp_q);
                end
            end
            if (k < 16) begin
                n_compared++;
                if (D_READY !== 1'b1) begin
                    n_mismatched++;
                    $display("[TB] FAIL stream_dready cycle %0d: got %b expected %b", k, D_READY, 1'b1);
                end
            end
            if ((k >= 3) && (k <= 16)) begin
                n_compared++;
                if (OCCUPANCY !== 4'd3) begin
                    n_mismatched++;
                    $display("[TB] FAIL stream_occ cycle %0d: got %0d expected %0d", k, OCCUPANCY, 3);
                end
            end
            next_cycle();
        end
        D_VALID = 1'b0;
        #1;
        n_compared++;
        if (OCCUPANCY !== 4'd0) begin
            n_mismatched++;
            $display("[TB] FAIL stream_drained_occ: got %0d expected %0d", OCCUPANCY, 0);
        end
        next_cycle();
    endtask

    // Fill with A1..A3 against a stalled output, confirm the pipe refuses
    // A4 and holds Q, then one ready cycle swaps A1 out for A4.
    task automatic test_backpressure();
        Q_READY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            D_VALID = 1'b1;
            D       = 8'(8'hA1 + k);
            #1;
            n_compared++;
            if (D_READY !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL bp_fill_dready %0d: got %b expected %b", k, D_READY, 1'b1);
            end
            next_cycle();
        end
        for (int k = 0; k < 2; k++) begin
            D_VALID = 1'b1;
            D       = 8'hA4;
            #1;
            n_compared++;
            if (D_READY !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL bp_full_dready %0d: got %b expected %b", k, D_READY, 1'b0);
            end
            n_compared++;
            if (OCCUPANCY !== 4'd3) begin
                n_mismatched++;
                $display("[TB] FAIL bp_full_occ %0d: got %0d expected %0d", k, OCCUPANCY, 3);
            end
            n_compared++;
            if (Q !== 8'hA1) begin
                n_mismatched++;
                $display("[TB] FAIL bp_stable_q %0d: got %h expected %h", k, Q, 8'hA1);
            end
            n_compared++;
            if (Q_VALID !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL bp_full_qvalid %0d: got %b expected %b", k, Q_VALID, 1'b1);
            end
            next_cycle();
        end
        Q_READY = 1'b1;
        #1;
        n_compared++;
        if (D_READY !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL bp_swap_dready: got %b expected %b", D_READY, 1'b1);
        end
        n_compared++;
        if (Q !== 8'hA1) begin
            n_mismatched++;
            $display("[TB] FAIL bp_swap_q: got %h expected %h", Q, 8'hA1);
        end
        next_cycle();
        Q_READY = 1'b0;
        D_VALID = 1'b0;
        #1;
        n_compared++;
        if (Q !== 8'hA2) begin
            n_mismatched++;
            $display("[TB] FAIL bp_after_swap_q: got %h expected %h", Q, 8'hA2);
        end
        n_compared++;
        if (OCCUPANCY !== 4'd3) begin
            n_mismatched++;
            $display("[TB] FAIL bp_after_swap_occ: got %0d expected %0d", OCCUPANCY, 3);
        end
        next_cycle();
        Q_READY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_compared++;
            if (Q_VALID !== 1'b1 || Q !== 8'(8'hA2 + k)) begin
                n_mismatched++;
                $display("[TB] FAIL bp_drain %0d: got valid=%b q=%h expected valid=1 q=%h", k, Q_VALID, Q, 8'(8'hA2 + k));
            end
            next_cycle();
        end
        #1;
        n_compared++;
        if (Q_VALID !== 1'b0 || OCCUPANCY !== 4'd0) begin
            n_mismatched++;
            $display("[TB] FAIL bp_empty: got valid=%b occ=%0d expected valid=0 occ=0", Q_VALID, OCCUPANCY);
        end
        next_cycle();
    endtask

    // A lone 0x55 runs to the stalled output, 0x66 follows two cycles later
    // and closes up behind it; both leave in order.
    task automatic test_bubble_collapse();
        Q_READY = 1'b0;
        for (int k = 0; k < 4; k++) begin
            D_VALID = (k == 0) || (k == 2);
            D       = (k == 0) ? 8'h55 : 8'h66;
            #1;
            if (D_VALID) begin
                n_compared++;
                if (D_READY !== 1'b1) begin
                    n_mismatched++;
                    $display("[TB] FAIL bubble_dready cycle %0d: got %b expected %b", k, D_READY, 1'b1);
                end
            end
            next_cycle();
        end
        #1;
        n_compared++;
        if (OCCUPANCY !== 4'd2) begin
            n_mismatched++;
            $display("[TB] FAIL bubble_occ: got %0d expected %0d", OCCUPANCY, 2);
        end
        n_compared++;
        if (Q_VALID !== 1'b1 || Q !== 8'h55) begin
            n_mismatched++;
            $display("[TB] FAIL bubble_head: got valid=%b q=%h expected valid=1 q=55", Q_VALID, Q);
        end
        next_cycle();
        Q_READY = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_compared++;
            if (Q_VALID !== 1'b1 || Q !== ((k == 0) ? 8'h55 : 8'h66)) begin
                n_mismatched++;
                $display("[TB] FAIL bubble_order %0d: got valid=%b q=%h expected valid=1 q=%h", k, Q_VALID, Q, (k == 0) ? 8'h55 : 8'h66);
            end
            next_cycle();
        end
        #1;
        n_compared++;
        if (Q_VALID !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL bubble_empty: got %b expected %b", Q_VALID, 1'b0);
        end
        next_cycle();
    endtask

    // Two words held, a one-cycle FLUSH discards them and blocks input.
    task automatic test_flush();
        Q_READY = 1'b0;
        for (int k = 0; k < 2; k++) begin
            D_VALID = 1'b1;
            D       = 8'(8'h11 * (k + 1));
            next_cycle();
        end
        D_VALID = 1'b0;
        #1;
        n_compared++;
        if (OCCUPANCY !== 4'd2) begin
            n_mismatched++;
            $display("[TB] FAIL flush_pre_occ: got %0d expected %0d", OCCUPANCY, 2);
        end
        next_cycle();
        FLUSH   = 1'b1;
        D_VALID = 1'b1;
        D       = 8'h33;
        Q_READY = 1'b1;
        #1;
        n_compared++;
        if (D_READY !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL flush_dready: got %b expected %b", D_READY, 1'b0);
        end
        n_compared++;
        if (Q_VALID !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL flush_qvalid: got %b expected %b", Q_VALID, 1'b0);
        end
        next_cycle();
        FLUSH   = 1'b0;
        D_VALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_compared++;
            if (OCCUPANCY !== 4'd0 || Q_VALID !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL flush_after %0d: got occ=%0d valid=%b expected occ=0 valid=0", k, OCCUPANCY, Q_VALID);
            end
            next_cycle();
        end
    endtask

    // Stream 0x30..0x3B with CE low in cycles 4..7 (and a FLUSH pulse in
    // cycle 5 that must be ignored). Q freezes at 0x31 during the stall and
    // the stream resumes with nothing lost or repeated.
    task automatic test_ce_stall();
        logic       stalled;
        logic       exp_qv;
        logic [7:0] exp_q;
        int         s;
        Q_READY = 1'b1;
        for (int c = 0; c < 21; c++) begin
            stalled = (c >= 4) && (c <= 7);
            CE      = !stalled;
            FLUSH   = (c == 5);
            s       = (c < 4) ? c : ((c <= 7) ? 4 : c - 4);
            D_VALID = (s < 12);
            D       = 8'(8'h30 + s);
            #1;
            exp_qv = (c >= 3) && (c <= 18) && !stalled;
            if (c == 3) begin
                exp_q = 8'h30;
            end else if (stalled) begin
                exp_q = 8'h31;
            end else begin
                exp_q = 8'(8'h31 + c - 8);
            end
            n_compared++;
            if (Q_VALID !== exp_qv) begin
                n_mismatched++;
                $display("[TB] FAIL ce_qvalid cycle %0d: got %b expected %b", c, Q_VALID, exp_qv);
            end
            n_compared++;
            if (D_READY !== !stalled) begin
                n_mismatched++;
                $display("[TB] FAIL ce_dready cycle %0d: got %b expected %b", c, D_READY, !stalled);
            end
            if ((c >= 3) && (c <= 18)) begin
                n_compared++;
                if (Q !== exp_q) begin
                    n_mismatched++;
                    $display("[TB] FAIL ce_q cycle %0d: got %h expected %h", c, Q, exp_q);
                end
            end
            if (stalled) begin
                n_compared++;
                if (OCCUPANCY !== 4'd3) begin
                    n_mismatched++;
                    $display("[TB] FAIL ce_occ cycle %0d: got %0d expected %0d", c, OCCUPANCY, 3);
                end
            end
            next_cycle();
        end
        CE    = 1'b1;
        FLUSH = 1'b0;
    endtask

    // Full pipe, one cycle of reset, then 0x7E accepted on the first edge
    // after release and seen at Q three cycles later.
    task automatic test_reset_midstream();
        Q_READY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            D_VALID = 1'b1;
            D       = 8'(8'hC1 + k);
            next_cycle();
        end
        D_VALID = 1'b0;
        #1;
        n_compared++;
        if (OCCUPANCY !== 4'd3) begin
            n_mismatched++;
            $display("[TB] FAIL rst_full_occ: got %0d expected %0d", OCCUPANCY, 3);
        end
        next_cycle();
        SCLR_N  = 1'b0;
        D_VALID = 1'b1;
        D       = 8'hEE;
        Q_READY = 1'b1;
        #1;
        n_compared++;
        if (D_READY !== 1'b0 || Q_VALID !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_during: got dready=%b qvalid=%b expected 0 0", D_READY, Q_VALID);
        end
        next_cycle();
        SCLR_N  = 1'b1;
        D_VALID = 1'b1;
        D       = 8'h7E;
        #1;
        n_compared++;
        if (Q !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL rst_after_q: got %h expected %h", Q, 8'h00);
        end
        n_compared++;
        if (Q_VALID !== 1'b0 || OCCUPANCY !== 4'd0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_after_state: got valid=%b occ=%0d expected valid=0 occ=0", Q_VALID, OCCUPANCY);
        end
        n_compared++;
        if (D_READY !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rst_after_dready: got %b expected %b", D_READY, 1'b1);
        end
        next_cycle();
        D_VALID = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            n_compared++;
            if (Q_VALID !== (k == 3)) begin
                n_mismatched++;
                $display("[TB] FAIL rst_latency cycle %0d: got %b expected %b", k, Q_VALID, (k == 3));
            end
            if (k == 3) begin
                n_compared++;
                if (Q !== 8'h7E) begin
                    n_mismatched++;
                    $display("[TB] FAIL rst_new_word: got %h expected %h", Q, 8'h7E);
                end
            end
            next_cycle();
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        SCLR_N  = 1'b0;
        CE      = 1'b1;
        FLUSH   = 1'b0;
        D       = 8'h00;
        D_VALID = 1'b0;
        Q_READY = 1'b0;
        $display("[TB] starting elastic_pipeline_v1_0 bench");
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble_collapse();
        test_flush();
        test_ce_stall();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/elastic_pipeline_v1_0.md
ELASTIC_PIPELINE_V1_0 -- requirements
Module: elastic_pipeline_v1_0

Interface
REQ-001 Parameter C_WIDTH, default 16, data width in bits (1..64).
REQ-002 Parameter C_PIPE_STAGES, default 3, number of register stages (1..8).
REQ-003 Port CLK  input  1  rising-edge clock; the only clock.
REQ-004 Port SCLR_N  input  1  reset, synchronous, active-low.
REQ-005 Port CE  input  1  clock enable; low freezes all state and blocks both handshakes.
REQ-006 Port FLUSH  input  1  synchronous discard of all held words.
REQ-007 Port D  input  C_WIDTH  upstream data.
REQ-008 Port D_VALID  input  1  upstream word present.
REQ-009 Port D_READY  output  1  pipeline accepts D this cycle.
REQ-010 Port Q  output  C_WIDTH  downstream data (last stage register).
REQ-011 Port Q_VALID  output  1  downstream word present.
REQ-012 Port Q_READY  input  1  downstream accepts Q this cycle.
REQ-013 Port OCCUPANCY  output  4  count of valid stages, 0..C_PIPE_STAGES.

Function
REQ-014 Each stage i SHALL hold a C_WIDTH data register and a valid bit v[i]; stage 0 is nearest D, stage C_PIPE_STAGES-1 drives Q.
REQ-015 Output transfer SHALL occur on a rising edge when Q_VALID and Q_READY are both 1; input transfer SHALL occur when D_VALID and D_READY are both 1.
REQ-016 Q_VALID SHALL equal v[last] AND CE AND NOT FLUSH (combinational).
REQ-017 Stage i SHALL advance (load from stage i-1, or D for i=0) when CE=1, FLUSH=0, and (v[i]=0 or stage i+1 advances); for the last stage "stage i+1 advances" means Q_READY=1.
REQ-018 D_READY SHALL equal the stage-0 advance condition, combinational, with no dependency on D_VALID.
REQ-019 On advance, v[i] SHALL take v[i-1] (D_VALID for stage 0); data registers SHALL load only when the incoming valid is 1, else hold.
REQ-020 Bubbles SHALL collapse: an empty stage SHALL accept from upstream even when downstream is stalled.
REQ-021 Latency from input transfer to Q_VALID SHALL be exactly C_PIPE_STAGES cycles when no stage is stalled.
REQ-022 Sustained throughput SHALL be one word per cycle with D_VALID=1 and Q_READY=1 continuously.
REQ-023 When full (OCCUPANCY=C_PIPE_STAGES) and Q_READY=0, D_READY SHALL be 0 and all state SHALL hold; with Q_READY=1 a full pipe SHALL accept and emit in the same cycle.
REQ-024 Words SHALL be delivered in order, none duplicated or dropped, except by FLUSH or reset.
REQ-025 FLUSH=1 (with CE=1) SHALL clear all v[i] on the next edge, force D_READY=0 and Q_VALID=0 that cycle; data registers hold. FLUSH with CE=0 SHALL have no effect.
REQ-026 CE=0 SHALL hold all registers and OCCUPANCY, force D_READY=0 and Q_VALID=0; Q SHALL hold its value.
REQ-027 OCCUPANCY SHALL be a registered count equal to the number of set v[i] after each edge.
REQ-028 Q SHALL remain stable while Q_VALID=1 and Q_READY=0.

Reset
REQ-029 SCLR_N=0 at a rising edge SHALL clear all v[i], all data registers to 0, and OCCUPANCY to 0, regardless of CE and FLUSH.
REQ-030 While SCLR_N=0, D_READY and Q_VALID SHALL be 0; reset mid-stream SHALL discard held words with no partial output.
REQ-031 On the first edge after SCLR_N returns to 1, the pipeline SHALL accept input if D_VALID=1 and CE=1.

Verification (C_WIDTH=8, C_PIPE_STAGES=3)
REQ-032 Streaming: D=0x01..0x10 on consecutive cycles, Q_READY=1 -> Q_VALID first high 3 cycles after first accept, Q=0x01..0x10 consecutive, OCCUPANCY steady at 3.
REQ-033 Backpressure: fill with 0xA1,0xA2,0xA3, Q_READY=0 -> D_READY=0, OCCUPANCY=3, Q=0xA1 stable; Q_READY=1 for one cycle -> 0xA1 out, 0xA4 accepted same cycle.
REQ-034 Bubble collapse: single word 0x55 with Q_READY=0, then 0x66 two cycles later -> both held, OCCUPANCY=2, output order 0x55,0x66.
REQ-035 FLUSH: OCCUPANCY=2, FLUSH pulse 1 cycle -> D_READY=0 that cycle, OCCUPANCY=0 after, no Q_VALID until new input.
REQ-036 CE stall: mid-stream CE=0 for 4 cycles -> all outputs frozen, D_READY=0, Q_VALID=0; on CE=1 stream resumes with no loss or duplication.
REQ-037 Reset: SCLR_N=0 for 1 cycle while full -> Q=0x00, Q_VALID=0, OCCUPANCY=0; next word 0x7E appears at Q after 3 cycles.
